// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-requester arbiter for the single data-memory port.
//               One transaction outstanding at a time. Responses are routed to
//               the requester that owns the transaction. Define DMEM_ARB_RR_EN
//               for round-robin tie-breaking; the default is fixed priority
//               with requester 0 winning ties.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [1:0]                  req_valid_i,
    output logic [1:0]                  req_ready_o,
    input  logic [2*ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [1:0]                  req_write_i,
    input  logic [2*DATA_WIDTH-1:0]     req_wdata_i,
    input  logic [2*(DATA_WIDTH/8)-1:0] req_wstrb_i,
    output logic [1:0]                  resp_valid_o,
    output logic [DATA_WIDTH-1:0]       resp_rdata_o,
    output logic                        mem_req_valid_o,
    input  logic                        mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]       mem_addr_o,
    output logic                        mem_write_o,
    output logic [DATA_WIDTH-1:0]       mem_wdata_o,
    output logic [(DATA_WIDTH/8)-1:0]   mem_wstrb_o,
    input  logic                        mem_resp_valid_i,
    input  logic [DATA_WIDTH-1:0]       mem_resp_rdata_i,
    output logic                        err_o
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       r_grant;
    logic       r_owner;
    logic       r_err;
    logic       w_err_set;
    logic       w_winner;
    logic       w_any_valid;
    logic       w_grant_valid;
    logic       w_arbitrate;
    logic       w_accept;

    assign w_any_valid   = |req_valid_i;
    assign w_grant_valid = r_grant ? req_valid_i[1] : req_valid_i[0];
    assign w_arbitrate   = (r_state == c_ST_IDLE) && w_any_valid;
    assign w_accept      = (r_state == c_ST_ISSUE) && mem_req_ready_i;

`ifdef DMEM_ARB_RR_EN
    logic r_rr;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        if (req_valid_i == 2'b11) begin
            w_winner = ~r_rr;
        end else begin
            w_winner = req_valid_i[1] & ~req_valid_i[0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr <= 1'b0;
        end else if (w_arbitrate) begin
            r_rr <= w_winner;
        end
    end
`else
    assign w_winner = req_valid_i[1] & ~req_valid_i[0];
`endif

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_grant <= 1'b0;
            r_owner <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_arbitrate) begin
                r_grant <= w_winner;
            end
            if (w_accept) begin
                r_owner <= r_grant;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // Next-state and protocol-error detection
    always_comb begin
        w_state_next = r_state;
        w_err_set    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (mem_resp_valid_i) begin
                    w_err_set = 1'b1;
                end
                if (w_any_valid) begin
                    w_state_next = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                if (mem_resp_valid_i || !w_grant_valid) begin
                    w_err_set = 1'b1;
                end
                // Once memory has taken the request its response must be
                // tracked, even if the requester misbehaved the same cycle.
                if (mem_req_ready_i) begin
                    w_state_next = c_ST_WAIT;
                end else if (!w_grant_valid) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            c_ST_WAIT: begin
                if (mem_resp_valid_i) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // Outputs: decoded from state and the memory-side handshakes only
    always_comb begin
        req_ready_o     = 2'b00;
        resp_valid_o    = 2'b00;
        resp_rdata_o    = '0;
        mem_req_valid_o = 1'b0;
        mem_addr_o      = '0;
        mem_write_o     = 1'b0;
        mem_wdata_o     = '0;
        mem_wstrb_o     = '0;
        case (r_state)
            c_ST_ISSUE: begin
                mem_req_valid_o = 1'b1;
                if (r_grant) begin
                    mem_addr_o  = req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH];
                    mem_write_o = req_write_i[1];
                    mem_wdata_o = req_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH];
                    mem_wstrb_o = req_wstrb_i[2*STRB_WIDTH-1:STRB_WIDTH];
                end else begin
                    mem_addr_o  = req_addr_i[ADDR_WIDTH-1:0];
                    mem_write_o = req_write_i[0];
                    mem_wdata_o = req_wdata_i[DATA_WIDTH-1:0];
                    mem_wstrb_o = req_wstrb_i[STRB_WIDTH-1:0];
                end
                req_ready_o[r_grant] = mem_req_ready_i;
            end
            c_ST_WAIT: begin
                if (mem_resp_valid_i) begin
                    resp_valid_o[r_owner] = 1'b1;
                    resp_rdata_o          = mem_resp_rdata_i;
                end
            end
            default: begin
            end
        endcase
    end

    assign err_o = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_addr;
    logic [1:0]  req_write;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic [1:0]  resp_valid;
    logic [31:0] resp_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        err;

    int n_checks;
    int n_fail;

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) u_dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_addr_i       (req_addr),
        .req_write_i      (req_write),
        .req_wdata_i      (req_wdata),
        .req_wstrb_i      (req_wstrb),
        .resp_valid_o     (resp_valid),
        .resp_rdata_o     (resp_rdata),
        .mem_req_valid_o  (mem_req_valid),
        .mem_req_ready_i  (mem_req_ready),
        .mem_addr_o       (mem_addr),
        .mem_write_o      (mem_write),
        .mem_wdata_o      (mem_wdata),
        .mem_wstrb_o      (mem_wstrb),
        .mem_resp_valid_i (mem_resp_valid),
        .mem_resp_rdata_i (mem_resp_rdata),
        .err_o            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid      = 2'b00;
        req_addr       = '0;
        req_write      = 2'b00;
        req_wdata      = '0;
        req_wstrb      = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (req_ready !== 2'b00 || resp_valid !== 2'b00 || mem_req_valid !== 1'b0 ||
            mem_addr !== 32'h0 || err !== 1'b0 || resp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b resp=%b mvalid=%b addr=%h err=%b rdata=%h, need all zero",
                     req_ready, resp_valid, mem_req_valid, mem_addr, err, resp_rdata);
        end
    endtask

    task automatic test_single_read();
        req_valid = 2'b01;
        req_addr  = 64'h0000_0000_0000_0100;
        #1;
        n_checks++;
        if (mem_req_valid !== 1'b0 || req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL read_idle: got mvalid=%b ready=%b, need 0/00", mem_req_valid, req_ready);
        end
        tick();
        mem_req_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 2'b01 || mem_req_valid !== 1'b1 || mem_addr !== 32'h100 || mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL read_issue: got ready=%b mvalid=%b addr=%h wr=%b, need 01/1/100/0",
                     req_ready, mem_req_valid, mem_addr, mem_write);
        end
        tick();
        req_valid      = 2'b00;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (resp_valid !== 2'b01 || resp_rdata !== 32'hDEAD_BEEF || mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_resp: got resp=%b rdata=%h mvalid=%b, need 01/deadbeef/0",
                     resp_valid, resp_rdata, mem_req_valid);
        end
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'h1234_5678;
        #1;
        n_checks++;
        if (resp_valid !== 2'b00 || resp_rdata !== 32'h0 || mem_req_valid !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL read_done: got resp=%b rdata=%h mvalid=%b err=%b, need 00/0/0/0",
                     resp_valid, resp_rdata, mem_req_valid, err);
        end
    endtask

    task automatic test_stalled_write();
        int pulses;
        pulses    = 0;
        req_valid = 2'b10;
        req_addr  = 64'h0000_0204_0000_0000;
        req_write = 2'b10;
        req_wdata = 64'h0000_AB00_0000_0000;
        req_wstrb = 8'b0010_0000;
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_req_ready = (i == 3);
            #1;
            n_checks++;
            if (mem_req_valid !== 1'b1 || mem_addr !== 32'h204 || mem_write !== 1'b1 ||
                mem_wdata !== 32'h0000_AB00 || mem_wstrb !== 4'b0010 ||
                req_ready !== ((i == 3) ? 2'b10 : 2'b00)) begin
                n_fail++;
                $display("FAIL write_issue[%0d]: got mv=%b a=%h w=%b d=%h s=%b rdy=%b, need 1/204/1/0000ab00/0010/%b",
                         i, mem_req_valid, mem_addr, mem_write, mem_wdata, mem_wstrb, req_ready,
                         (i == 3) ? 2'b10 : 2'b00);
            end
            if (req_ready[1]) pulses++;
            tick();
        end
        req_valid      = 2'b00;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        #1;
        n_checks++;
        if (pulses != 1 || resp_valid !== 2'b10) begin
            n_fail++;
            $display("FAIL write_resp: got pulses=%0d resp=%b, need 1/10", pulses, resp_valid);
        end
        tick();
        mem_resp_valid = 1'b0;
        clear_inputs();
        #1;
    endtask

    task automatic test_contention();
        logic [3:0] exp_order;
        logic       w;
`ifdef DMEM_ARB_RR_EN
        exp_order = 4'b0101;
`else
        exp_order = 4'b0000;
`endif
        apply_reset();
        req_valid = 2'b11;
        req_addr  = 64'h0000_0020_0000_0010;
        for (int k = 0; k < 4; k++) begin
            w = exp_order[k];
            tick();
            mem_req_ready = 1'b1;
            #1;
            n_checks++;
            if (mem_addr !== (w ? 32'h20 : 32'h10) || req_ready !== (w ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL contention_grant[%0d]: got addr=%h ready=%b, need addr=%h ready=%b",
                         k, mem_addr, req_ready, w ? 32'h20 : 32'h10, w ? 2'b10 : 2'b01);
            end
            tick();
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b1;
            #1;
            n_checks++;
            if (resp_valid !== (w ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL contention_resp[%0d]: got resp=%b, need %b", k, resp_valid, w ? 2'b10 : 2'b01);
            end
            tick();
            mem_resp_valid = 1'b0;
        end
        req_valid = 2'b00;
        #1;
    endtask

    task automatic test_spurious_resp();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hCAFE_F00D;
        #1;
        n_checks++;
        if (resp_valid !== 2'b00 || resp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL spurious_dropped: got resp=%b rdata=%h, need 00/0", resp_valid, resp_rdata);
        end
        tick();
        mem_resp_valid = 1'b0;
        #1;
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL spurious_err: got err=%b, need 1", err);
        end
        req_valid = 2'b01;
        req_addr  = 64'h0000_0000_0000_0040;
        tick();
        mem_req_ready = 1'b1;
        tick();
        req_valid      = 2'b00;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h0000_0055;
        #1;
        n_checks++;
        if (resp_valid !== 2'b01 || resp_rdata !== 32'h55 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL sticky_err: got resp=%b rdata=%h err=%b, need 01/55/1", resp_valid, resp_rdata, err);
        end
        tick();
        clear_inputs();
        #1;
    endtask

    task automatic test_reset_in_wait();
        req_valid = 2'b01;
        req_addr  = 64'h0000_0000_0000_0080;
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        req_valid     = 2'b00;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 2'b00 || resp_valid !== 2'b00 || mem_req_valid !== 1'b0 ||
            mem_addr !== 32'h0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got ready=%b resp=%b mvalid=%b addr=%h err=%b, need all zero",
                     req_ready, resp_valid, mem_req_valid, mem_addr, err);
        end
        tick();
        rst       = 1'b0;
        req_valid = 2'b01;
        req_addr  = 64'h0000_0000_0000_0300;
        tick();
        mem_req_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 2'b01 || mem_addr !== 32'h300) begin
            n_fail++;
            $display("FAIL post_reset_issue: got ready=%b addr=%h, need 01/300", req_ready, mem_addr);
        end
        tick();
        req_valid      = 2'b00;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h0BAD_CAFE;
        #1;
        n_checks++;
        if (resp_valid !== 2'b01 || resp_rdata !== 32'h0BAD_CAFE || err !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_resp: got resp=%b rdata=%h err=%b, need 01/0badcafe/0",
                     resp_valid, resp_rdata, err);
        end
        tick();
        clear_inputs();
        #1;
    endtask

    task automatic test_drop_valid();
        req_valid = 2'b01;
        req_addr  = 64'h0000_0000_0000_0500;
        tick();
        req_valid = 2'b00;
        #1;
        n_checks++;
        if (req_ready !== 2'b00 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_issue: got ready=%b err=%b, need 00/0", req_ready, err);
        end
        tick();
        n_checks++;
        if (err !== 1'b1 || mem_req_valid !== 1'b0 || mem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL drop_idle: got err=%b mvalid=%b addr=%h, need 1/0/0", err, mem_req_valid, mem_addr);
        end
        mem_resp_valid = 1'b1;
        #1;
        n_checks++;
        if (resp_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL drop_no_wait: got resp=%b, need 00", resp_valid);
        end
        tick();
        clear_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_stalled_write();
        test_contention();
        test_spurious_resp();
        test_reset_in_wait();
        test_drop_valid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
